// File: rtl/lz77_decode_sequencer.sv
// Streams (pos,len,char) triples from code memory into an LZ77 decoder and writes each decoded
// byte to output memory; a 4-entry prefetch FIFO keeps the decoder fed one triple-cycle per clock.
module lz77_decode_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        cmem_re,
  output logic [9:0]  cmem_addr,
  input  logic [14:0] cmem_rdata,
  output logic        dec_reset,
  output logic [3:0]  code_pos,
  output logic [2:0]  code_len,
  output logic [7:0]  chardata,
  input  logic [7:0]  dec_char,
  input  logic        dec_finish,
  output logic        omem_we,
  output logic [11:0] omem_addr,
  output logic [7:0]  omem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StPreload = 3'd1;
  localparam logic [2:0] StRun     = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StErr     = 3'd4;

  localparam logic [7:0] EndChar  = 8'h24;
  localparam logic [9:0] LastAddr = 10'd1023;

  logic [2:0]  state_q, state_d;
  logic [14:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        rd_pend_q;
  logic        end_q;
  logic        err_q, err_d;
  logic [14:0] cur_q, cur_d;
  logic [2:0]  rem_q, rem_d;
  logic        cur_valid_q, cur_valid_d;
  logic        present_q;
  logic [9:0]  cmem_addr_q;
  logic [11:0] omem_addr_q;

  logic        active;
  logic        push, push_end, pop, clear;
  logic        present;
  logic        overrun;
  logic [2:0]  pending_sum;
  logic [14:0] head;

  assign active      = (state_q == StPreload) || (state_q == StRun);
  assign push        = rd_pend_q && active;
  assign push_end    = push && (cmem_rdata[7:0] == EndChar);
  assign pending_sum = count_q + {2'b00, rd_pend_q};
  // The end check includes the word arriving this cycle so nothing past the terminator is fetched.
  assign cmem_re     = active && (pending_sum < 3'd4) && !end_q && !push_end;
  assign overrun     = cmem_re && (cmem_addr_q == LastAddr);
  assign head        = fifo_q[rd_ptr_q];
  assign present     = (state_q == StRun) && cur_valid_q && !dec_finish;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    cur_valid_d = cur_valid_q;
    pop         = 1'b0;
    clear       = 1'b0;

    case (state_q)
      StIdle, StErr: begin
        if (start) begin
          clear       = 1'b1;
          err_d       = 1'b0;
          cur_valid_d = 1'b0;
          state_d     = StPreload;
        end
      end
      StPreload: begin
        if ((count_q >= 3'd2) || ((count_q == 3'd1) && end_q)) begin
          pop     = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (dec_finish) begin
          cur_valid_d = 1'b0;
          state_d     = StDone;
        end else if (cur_valid_q) begin
          if (rem_q != 3'd0) begin
            rem_d = rem_q - 3'd1;
          end else if (count_q != 3'd0) begin
            pop = 1'b1;
          end else if (end_q) begin
            // Terminator already presented: hold until the decoder reports finish.
            cur_valid_d = 1'b0;
          end else begin
            err_d       = 1'b1;
            cur_valid_d = 1'b0;
            state_d     = StErr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (pop) begin
      cur_d       = head;
      rem_d       = head[10:8];
      cur_valid_d = 1'b1;
    end

    if (overrun) begin
      err_d       = 1'b1;
      cur_valid_d = 1'b0;
      state_d     = StErr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      rd_pend_q   <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      cur_q       <= 15'd0;
      rem_q       <= 3'd0;
      cur_valid_q <= 1'b0;
      present_q   <= 1'b0;
      cmem_addr_q <= 10'd0;
      omem_addr_q <= 12'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      cur_valid_q <= cur_valid_d;
      present_q   <= present;
      if (clear) begin
        wr_ptr_q    <= 2'd0;
        rd_ptr_q    <= 2'd0;
        count_q     <= 3'd0;
        rd_pend_q   <= 1'b0;
        end_q       <= 1'b0;
        cmem_addr_q <= 10'd0;
        omem_addr_q <= 12'd0;
      end else begin
        rd_pend_q <= cmem_re;
        count_q   <= count_q + {2'b00, push} - {2'b00, pop};
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 2'd1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 2'd1;
        end
        if (push_end) begin
          end_q <= 1'b1;
        end
        if (cmem_re) begin
          cmem_addr_q <= cmem_addr_q + 10'd1;
        end
        if (omem_we) begin
          omem_addr_q <= omem_addr_q + 12'd1;
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmem_rdata;
    end
  end

  assign cmem_addr  = cmem_addr_q;
  assign dec_reset  = (state_q != StRun);
  assign code_pos   = cur_q[14:11];
  assign code_len   = cur_q[10:8];
  assign chardata   = cur_q[7:0];
  // Decoder output is registered, so each presented cycle is written back one cycle later.
  assign omem_we    = (state_q == StRun) && present_q;
  assign omem_addr  = omem_addr_q;
  assign omem_wdata = omem_we ? dec_char : 8'h00;
  assign busy       = active;
  assign done       = (state_q == StDone);
  assign err        = err_q;

endmodule

// File: tb/tb_lz77_decode_sequencer.sv
// Directed bench: code-memory and LZ77-decoder models around the sequencer, checked against
// hand-computed output streams.
module tb_lz77_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cmem_re;
  logic [9:0]  cmem_addr;
  logic [14:0] cmem_rdata = 15'd0;
  logic        dec_reset;
  logic [3:0]  code_pos;
  logic [2:0]  code_len;
  logic [7:0]  chardata;
  logic [7:0]  dec_char = 8'h00;
  logic        dec_finish = 1'b0;
  logic        omem_we;
  logic [11:0] omem_addr;
  logic [7:0]  omem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  lz77_decode_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmem_re    (cmem_re),
    .cmem_addr  (cmem_addr),
    .cmem_rdata (cmem_rdata),
    .dec_reset  (dec_reset),
    .code_pos   (code_pos),
    .code_len   (code_len),
    .chardata   (chardata),
    .dec_char   (dec_char),
    .dec_finish (dec_finish),
    .omem_we    (omem_we),
    .omem_addr  (omem_addr),
    .omem_wdata (omem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Code memory: synchronous read, data valid the cycle after cmem_re.
  logic [14:0] cmem [1024];
  always @(posedge clk) begin
    if (cmem_re) cmem_rdata <= cmem[cmem_addr];
  end

  // Decoder model: copies hist[pos] for len cycles, then emits char; hist[0] is the newest byte.
  logic [7:0] hist [16];
  int         dk = 0;
  logic [7:0] dc;
  always @(posedge clk) begin
    if (dec_reset) begin
      dk = 0;
      for (int i = 0; i < 16; i++) hist[i] = 8'h00;
      dec_char   <= 8'h00;
      dec_finish <= 1'b0;
    end else begin
      if (dk < int'(code_len)) begin
        dc = hist[code_pos];
        dk++;
      end else begin
        dc = chardata;
        dk = 0;
      end
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = dc;
      dec_char   <= dc;
      dec_finish <= (dc == 8'h24);
    end
  end

  // Output memory and event counters.
  logic [7:0] omem [4096];
  int  wr_cnt, done_cnt, re_cnt, re_gap, we_gap;
  bit  wr_started;
  bit  stats_clr = 1'b1;
  int  gap_limit = -1;
  always @(negedge clk) begin
    if (stats_clr) begin
      wr_cnt = 0; done_cnt = 0; re_cnt = 0; re_gap = 0; we_gap = 0; wr_started = 0;
      for (int i = 0; i < 16; i++) omem[i] = 8'h00;
    end else begin
      if (omem_we) begin
        omem[omem_addr] = omem_wdata;
        wr_cnt++;
        wr_started = 1;
      end else if (wr_started && busy) begin
        we_gap++;
      end
      if (done) done_cnt++;
      if (cmem_re) re_cnt++;
      if (busy && !cmem_re && int'(cmem_addr) <= gap_limit) re_gap++;
    end
  end

  logic [50:0] outs;
  assign outs = {cmem_re, cmem_addr, dec_reset, code_pos, code_len, chardata,
                 omem_we, omem_addr, omem_wdata, busy, done, err};
  logic [50:0] rst_outs_exp;

  function automatic logic [14:0] word(input logic [3:0] p, input logic [2:0] l,
                                       input logic [7:0] c);
    return {p, l, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n literals 'A'.. followed by the terminator; remaining memory zero.
  task automatic load_lits(input int n);
    for (int i = 0; i < 1024; i++) cmem[i] = 15'd0;
    for (int i = 0; i < n; i++) cmem[i] = word(4'd0, 3'd0, 8'h41 + 8'(i));
    cmem[n] = word(4'd0, 3'd0, 8'h24);
  endtask

  task automatic check_lits(input string tag, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = 8'h41 + 8'(i);
      check_eq({tag, "_byte"}, omem[i], e);
    end
    check_eq({tag, "_end"}, omem[n], 8'h24);
  endtask

  task automatic wait_done(input string tag, input int budget, output int addr);
    bit got = 0;
    addr = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        got  = 1;
        addr = int'(omem_addr);
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_run(input string tag, input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy && !dec_reset) begin
        got = 1;
        break;
      end
      tick();
    end
    check_eq({tag, "_run_seen"}, 64'(got), 64'd1);
  endtask

  initial begin
    int  addr;
    bit  got;
    logic [7:0] exp2 [5];
    rst_outs_exp = 51'd1 << 39;
    reset = 1'b0;
    start = 1'b0;
    load_lits(2);
    repeat (3) tick();
    check_eq("rst_outs", outs, rst_outs_exp);
    reset = 1'b1;
    tick();
    check_eq("idle_outs", outs, rst_outs_exp);
    stats_clr = 1'b0;

    // Literals A, B, $.
    load_lits(2);
    clear_stats();
    pulse_start();
    wait_done("s1", 200, addr);
    check_eq("s1_omem_addr", addr, 3);
    repeat (5) tick();
    check_eq("s1_writes", wr_cnt, 3);
    check_eq("s1_done_once", done_cnt, 1);
    check_eq("s1_reads", re_cnt, 3);
    check_lits("s1", 2);

    // Copy triple: a, (pos0,len2,b), $ -> model emits a a a b $.
    for (int i = 0; i < 1024; i++) cmem[i] = 15'd0;
    cmem[0] = word(4'd0, 3'd0, 8'h61);
    cmem[1] = word(4'd0, 3'd2, 8'h62);
    cmem[2] = word(4'd0, 3'd0, 8'h24);
    exp2[0] = 8'h61; exp2[1] = 8'h61; exp2[2] = 8'h61; exp2[3] = 8'h62; exp2[4] = 8'h24;
    clear_stats();
    pulse_start();
    wait_done("s2", 200, addr);
    check_eq("s2_omem_addr", addr, 5);
    check_eq("s2_writes", wr_cnt, 5);
    check_eq("s2_no_bubble", we_gap, 0);
    for (int i = 0; i < 5; i++) check_eq("s2_byte", omem[i], exp2[i]);

    // Ten back-to-back literals: fetch never stalls until the terminator is read.
    load_lits(10);
    gap_limit = 10;
    clear_stats();
    pulse_start();
    wait_done("s3", 200, addr);
    gap_limit = -1;
    check_eq("s3_omem_addr", addr, 11);
    check_eq("s3_writes", wr_cnt, 11);
    check_eq("s3_re_gaps", re_gap, 0);
    check_eq("s3_we_gaps", we_gap, 0);
    check_eq("s3_err", err, 0);
    check_lits("s3", 10);

    // Reset in the third RUN cycle, then a fresh stream from address 0.
    load_lits(10);
    clear_stats();
    pulse_start();
    wait_run("s4", 50);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("s4_rst_outs", outs, rst_outs_exp);
    reset = 1'b1;
    load_lits(2);
    clear_stats();
    pulse_start();
    wait_done("s4b", 200, addr);
    check_eq("s4b_omem_addr", addr, 3);
    check_eq("s4b_writes", wr_cnt, 3);
    check_eq("s4b_reads", re_cnt, 3);
    check_lits("s4b", 2);

    // No terminator anywhere: overrun after reading address 1023.
    for (int i = 0; i < 1024; i++) cmem[i] = word(4'd0, 3'd0, 8'h61);
    clear_stats();
    pulse_start();
    got = 0;
    for (int i = 0; i < 1500; i++) begin
      if (err) begin
        got = 1;
        break;
      end
      tick();
    end
    check_eq("s5_err", 64'(got), 64'd1);
    repeat (3) tick();
    check_eq("s5_err_sticky", err, 1);
    check_eq("s5_dec_reset", dec_reset, 1);
    check_eq("s5_cmem_re", cmem_re, 0);
    check_eq("s5_omem_we", omem_we, 0);
    check_eq("s5_busy", busy, 0);
    check_eq("s5_no_done", done_cnt, 0);
    check_eq("s5_reads", re_cnt, 1024);

    // Start from ERR, with a spurious start pulse during RUN.
    load_lits(10);
    clear_stats();
    pulse_start();
    check_eq("s6_err_clr", err, 0);
    wait_run("s6", 50);
    tick();
    pulse_start();
    wait_done("s6", 200, addr);
    check_eq("s6_omem_addr", addr, 11);
    repeat (5) tick();
    check_eq("s6_writes", wr_cnt, 11);
    check_eq("s6_done_once", done_cnt, 1);
    check_eq("s6_reads", re_cnt, 11);
    check_lits("s6", 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
